// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
// The memory answers combinationally for the current word address.
interface instr_fetch_if #(
    parameter int memory_addr_size = 6
) ();
    logic [memory_addr_size-1:0] imem_addr;
    logic [31:0]                 imem_data;

    modport master (output imem_addr, input  imem_data);
    modport slave  (input  imem_addr, output imem_data);
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills
// the IF/ID register; handles stall, redirect, EBREAK halt and misaligned faults.
module instr_fetch #(
    parameter int          memory_size      = 64,
    parameter int          memory_addr_size = 6,
    parameter logic [31:0] reset_pc         = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_if.master       imem,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_target,
    output logic [31:0]         if_instr,
    output logic [31:0]         if_pc,
    output logic                if_valid,
    output logic [31:0]         pc,
    output logic                halted,
    output logic                fault
);
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    // Address wrap relies on slicing the PC, so depth must be a power of two.
    if (memory_size != (1 << memory_addr_size)) begin : g_bad_cfg
        $error("instr_fetch: memory_size must equal 2**memory_addr_size");
    end

    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        vld_q, vld_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= reset_pc;
            instr_q  <= NOP;
            ifpc_q   <= 32'h0;
            vld_q    <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ifpc_q   <= ifpc_d;
            vld_q    <= vld_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        ifpc_d   = ifpc_q;
        vld_d    = vld_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        if (redirect) begin
            // A misaligned target is never loaded; fetch parks until a good redirect.
            if (redirect_target[1:0] != 2'b00) begin
                fault_d  = 1'b1;
                halted_d = 1'b1;
                vld_d    = 1'b0;
                state_d  = HALTED;
            end else begin
                pc_d     = redirect_target;
                vld_d    = 1'b0;
                instr_d  = NOP;
                halted_d = 1'b0;
                state_d  = FETCH;
            end
        end else begin
            unique case (state_q)
                IDLE:   state_d = FETCH;
                FETCH: begin
                    if (!stall) begin
                        instr_d = imem.imem_data;
                        ifpc_d  = pc_q;
                        vld_d   = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        if (imem.imem_data == EBREAK) begin
                            state_d  = HALTED;
                            halted_d = 1'b1;
                        end
                    end
                end
                HALTED: if (!stall) vld_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    assign imem.imem_addr = pc_q[memory_addr_size+1:2];
    assign if_instr       = instr_q;
    assign if_pc          = ifpc_q;
    assign if_valid       = vld_q;
    assign pc             = pc_q;
    assign halted         = halted_q;
    assign fault          = fault_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, stall, redirect, EBREAK halt,
// misaligned fault, async reset and address wrap from a high reset PC.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect;
    logic [31:0] redirect_target;
    logic [31:0] if_instr, if_pc, pc;
    logic        if_valid, halted, fault;
    logic [31:0] if_instr2, if_pc2, pc2;
    logic        if_valid2, halted2, fault2;
    logic [31:0] mem [64];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch_if #(.memory_addr_size(6)) bus  ();
    instr_fetch_if #(.memory_addr_size(6)) bus2 ();
    assign bus.imem_data  = mem[bus.imem_addr];
    assign bus2.imem_data = mem[bus2.imem_addr];

    instr_fetch #(.memory_size(64), .memory_addr_size(6), .reset_pc(32'h0)) dut (
        .clk(clk), .rst(rst), .imem(bus), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .if_instr(if_instr), .if_pc(if_pc),
        .if_valid(if_valid), .pc(pc), .halted(halted), .fault(fault));

    instr_fetch #(.memory_size(64), .memory_addr_size(6), .reset_pc(32'hFC)) dut2 (
        .clk(clk), .rst(rst), .imem(bus2), .stall(1'b0), .redirect(1'b0),
        .redirect_target(32'h0), .if_instr(if_instr2), .if_pc(if_pc2),
        .if_valid(if_valid2), .pc(pc2), .halted(halted2), .fault(fault2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_8113;
        mem[2] = 32'h0020_81B3;
        mem[3] = 32'h0000_0013;
        mem[5] = 32'h0010_0073;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        #3;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", if_instr, 32'h13);
        chk("rst_ifpc", if_pc, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_addr", {26'h0, bus.imem_addr}, 32'h0);
        chk("rst2_pc", pc2, 32'hFC);
        chk("rst2_addr", {26'h0, bus2.imem_addr}, 32'd63);
        #9 rst = 1'b0;

        step(); // IDLE: no capture
        chk("idle_valid", {31'h0, if_valid}, 32'h0);
        chk("idle_pc", pc, 32'h0);
        step();
        chk("f0_instr", if_instr, 32'h0050_0093);
        chk("f0_pc", if_pc, 32'h0);
        chk("f0_valid", {31'h0, if_valid}, 32'h1);
        chk("f0_addr", {26'h0, bus.imem_addr}, 32'h1);
        chk("wrap2_pc", pc2, 32'h100);
        chk("wrap2_addr", {26'h0, bus2.imem_addr}, 32'h0);
        chk("wrap2_ifpc", if_pc2, 32'hFC);
        chk("wrap2_instr", if_instr2, 32'hA000_003F);
        step();
        chk("f1_instr", if_instr, 32'h0010_8113);
        chk("f1_pc", if_pc, 32'h4);
        chk("f1_addr", {26'h0, bus.imem_addr}, 32'h2);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc, 32'h8);
            chk("stall_instr", if_instr, 32'h0010_8113);
            chk("stall_ifpc", if_pc, 32'h4);
        end
        stall = 1'b0;
        step();
        chk("f2_pc", if_pc, 32'h8);
        chk("f2_instr", if_instr, 32'h0020_81B3);
        chk("f2_addr", {26'h0, bus.imem_addr}, 32'h3);
        step();
        chk("f3_pc", if_pc, 32'hC);
        chk("f3_instr", if_instr, 32'h0000_0013);

        redirect = 1'b1; redirect_target = 32'h8;
        step();
        chk("rd8_pc", pc, 32'h8);
        chk("rd8_valid", {31'h0, if_valid}, 32'h0);
        stall = 1'b1; redirect_target = 32'h20;
        step();
        chk("rdst_pc", pc, 32'h20);
        chk("rdst_valid", {31'h0, if_valid}, 32'h0);
        chk("rdst_instr", if_instr, 32'h13);
        chk("rdst_addr", {26'h0, bus.imem_addr}, 32'h8);
        stall = 1'b0; redirect = 1'b0;
        step();
        chk("f20_ifpc", if_pc, 32'h20);
        chk("f20_instr", if_instr, 32'hA000_0008);
        chk("f20_valid", {31'h0, if_valid}, 32'h1);

        redirect = 1'b1; redirect_target = 32'h10;
        step();
        redirect = 1'b0;
        step();
        chk("f10_instr", if_instr, 32'hA000_0004);
        step();
        chk("eb_instr", if_instr, 32'h0010_0073);
        chk("eb_valid", {31'h0, if_valid}, 32'h1);
        chk("eb_halted", {31'h0, halted}, 32'h1);
        chk("eb_pc", pc, 32'h18);
        step();
        chk("hlt_valid", {31'h0, if_valid}, 32'h0);
        chk("hlt_pc", pc, 32'h18);
        chk("hlt_halted", {31'h0, halted}, 32'h1);
        step();
        chk("hlt2_pc", pc, 32'h18);
        redirect = 1'b1; redirect_target = 32'h0;
        step();
        chk("res_halted", {31'h0, halted}, 32'h0);
        chk("res_pc", pc, 32'h0);
        redirect = 1'b0;
        step();
        chk("res_ifpc", if_pc, 32'h0);
        chk("res_instr", if_instr, 32'h0050_0093);
        chk("res_valid", {31'h0, if_valid}, 32'h1);

        redirect = 1'b1; redirect_target = 32'h22;
        step();
        chk("mis_fault", {31'h0, fault}, 32'h1);
        chk("mis_halted", {31'h0, halted}, 32'h1);
        chk("mis_pc", pc, 32'h4);
        chk("mis_valid", {31'h0, if_valid}, 32'h0);
        redirect_target = 32'h10;
        step();
        chk("fres_pc", pc, 32'h10);
        chk("fres_halted", {31'h0, halted}, 32'h0);
        redirect = 1'b0;
        step();
        chk("fres_ifpc", if_pc, 32'h10);
        chk("fres_valid", {31'h0, if_valid}, 32'h1);
        chk("fres_fault", {31'h0, fault}, 32'h1);
        step();

        #2 rst = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_valid", {31'h0, if_valid}, 32'h0);
        chk("arst_fault", {31'h0, fault}, 32'h0);
        chk("arst_instr", if_instr, 32'h13);
        chk("arst_ifpc", if_pc, 32'h0);
        chk("arst2_addr", {26'h0, bus2.imem_addr}, 32'd63);
        #3 rst = 1'b0;
        step();
        chk("arst_idle", {31'h0, if_valid}, 32'h0);
        step();
        chk("arst_f0", if_instr, 32'h0050_0093);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
